// File: rtl/nco_ctrl_pkg.sv
// Shared types and default widths for the carrier NCO sweep controller and its NCO.
package nco_ctrl_pkg;

   localparam int NCO_WIDTH = 64;
   localparam int NCO_CNT_W = 16;

   typedef enum logic {
      NCO_IDLE  = 1'b0,
      NCO_DWELL = 1'b1
   } nco_state_e;

endpackage

// File: rtl/nco_dwell_timer.sv
// Loadable dwell down-counter: load takes max(d,1), last flags a count of one.
module nco_dwell_timer
   import nco_ctrl_pkg::*;
#(
   parameter int CNT_W = NCO_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] d,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = (d == '0) ? CNT_W'(1) : d;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer driving the carrier NCO phase increment.
// Optional NCO_SWEEP_LOOP_EN adds a 'loop' input that restarts the sweep after each pass.
//
// state     | meaning
// NCO_IDLE  | waiting for a descriptor; outputs hold last tone
// NCO_DWELL | holding the current tone until the dwell timer expires
module nco_sweep_ctrl
   import nco_ctrl_pkg::*;
#(
   parameter int WIDTH = NCO_WIDTH,
   parameter int CNT_W = NCO_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_start_inc,
   input  logic [WIDTH-1:0] cfg_step_inc,
   input  logic [CNT_W-1:0] cfg_num_steps,
   input  logic [CNT_W-1:0] cfg_dwell,
`ifdef NCO_SWEEP_LOOP_EN
   input  logic             loop,
`endif
   input  logic             abort,
   output logic [WIDTH-1:0] phase_inc_carr,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] step_idx
);

   nco_state_e       state_q, state_d;
   logic [WIDTH-1:0] phase_q, phase_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] step_q, step_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic             done_q, done_d;
   logic             hs;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_last;

   assign cfg_ready = (state_q == NCO_IDLE) && !abort;
   assign hs        = cfg_valid && cfg_ready;

   nco_dwell_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tmr_load),
      .en    (state_q == NCO_DWELL),
      .d     (tmr_val),
      .last  (tmr_last)
   );

   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      start_d  = start_q;
      step_d   = step_q;
      num_d    = num_q;
      dwell_d  = dwell_q;
      idx_d    = idx_q;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = dwell_q;
      case (state_q)
         NCO_IDLE: begin
            if (hs) begin
               start_d  = cfg_start_inc;
               step_d   = cfg_step_inc;
               num_d    = cfg_num_steps;
               dwell_d  = cfg_dwell;
               phase_d  = cfg_start_inc;
               idx_d    = '0;
               tmr_load = 1'b1;
               tmr_val  = cfg_dwell;
               state_d  = NCO_DWELL;
            end
         end
         NCO_DWELL: begin
            // abort wins over both tone advance and completion
            if (abort) begin
               state_d = NCO_IDLE;
            end else if (tmr_last) begin
               if (idx_q == num_q) begin
                  done_d = 1'b1;
`ifdef NCO_SWEEP_LOOP_EN
                  if (loop) begin
                     phase_d  = start_q;
                     idx_d    = '0;
                     tmr_load = 1'b1;
                  end else begin
                     state_d = NCO_IDLE;
                  end
`else
                  state_d = NCO_IDLE;
`endif
               end else begin
                  phase_d  = phase_q + step_q;
                  idx_d    = idx_q + CNT_W'(1);
                  tmr_load = 1'b1;
               end
            end
         end
         default: state_d = NCO_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= NCO_IDLE;
         phase_q <= '0;
         start_q <= '0;
         step_q  <= '0;
         num_q   <= '0;
         dwell_q <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         start_q <= start_d;
         step_q  <= step_d;
         num_q   <= num_d;
         dwell_q <= dwell_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   assign phase_inc_carr = phase_q;
   assign step_idx       = idx_q;
   assign busy           = (state_q == NCO_DWELL);
   assign done           = done_q;

endmodule

// File: doc/nco_sweep_ctrl.md
# nco_sweep_ctrl

Sequencer for the carrier NCO: accepts a sweep description (start increment, step, number of steps, dwell) over a valid/ready handshake. It then drives `phase_inc_carr` of the NCO through a stepped frequency ramp, holding each tone for a programmed number of clocks. The block sits between the host/config logic and the NCO's `phase_inc_carr` input, and its output width matches the NCO accumulator.

## Interface
- `WIDTH`, 64, phase-increment width; equals NCO accumulator width.
- `CNT_W`, 16, width of step-count and dwell-count fields.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  sweep descriptor valid.
- `cfg_ready`  out  1  block can accept a descriptor; high only in IDLE.
- `cfg_start_inc`  in  WIDTH  first tone phase increment.
- `cfg_step_inc`  in  WIDTH  per-step increment, two's complement; negative values give a down-sweep.
- `cfg_num_steps`  in  CNT_W  number of steps; the sweep emits `cfg_num_steps+1` tones.
- `cfg_dwell`  in  CNT_W  clocks per tone; 0 is treated as 1.
- `abort`  in  1  terminate the sweep immediately.
- `phase_inc_carr`  out  WIDTH  registered increment to the NCO.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse on normal sweep completion.
- `step_idx`  out  CNT_W  index of the current tone, 0-based.

## Operation
- FSM has two states: IDLE and DWELL.
- IDLE:
  - `cfg_ready`=1.
  - Handshake fires when `cfg_valid && cfg_ready`.
  - On handshake, all fields are latched and the next state is DWELL.
  - In the same edge: `phase_inc_carr`<=`cfg_start_inc`, `step_idx`<=0, dwell counter<=max(`cfg_dwell`,1).
- DWELL:
  - Dwell counter decrements each clock.
  - When the counter is 1 and `step_idx`==latched num_steps: `done` pulses for one cycle and the next state is IDLE.
  - When the counter is 1 and `step_idx`!=latched num_steps:
    - `phase_inc_carr`<=`phase_inc_carr`+step, modulo 2^WIDTH; wrap-around is silent.
    - `step_idx`++ and the dwell counter reloads.
    - There is no gap cycle between tones.
- `abort`:
  - Highest priority.
  - In DWELL it forces IDLE on the next edge, with no `done` pulse.
  - In IDLE it blocks acceptance in that cycle: `cfg_ready` is forced low while `abort`=1.
- After completion or abort, `phase_inc_carr` and `step_idx` hold their last values. The NCO keeps running at the final tone.
- `busy` = (state==DWELL).
- Config inputs are sampled only at handshake; later changes have no effect mid-sweep.

## Timing
- Reset values: `phase_inc_carr`=0, `step_idx`=0, `busy`=0, `done`=0, state=IDLE. `cfg_ready`=1 once `rst_n` deasserts, unless `abort` is high.
- Reset mid-sweep takes effect immediately (async) and produces no `done`.
- Latency: `phase_inc_carr` shows the start tone on the first edge after handshake, so the NCO uses it one cycle later.
- Each tone is present for exactly max(D,1) cycles.
- Total busy cycles = (N+1)·max(D,1).
- `done` is asserted on the edge that returns to IDLE. `cfg_ready` is high in the same cycle, so back-to-back sweeps are possible with no gap beyond that cycle.
- `done` and `abort` never both take effect: if `abort` is high on the final dwell cycle, `done` is suppressed.

## Configuration
- `NCO_SWEEP_LOOP_EN`
  - Defined: adds input port `loop` (1 bit).
  - With `loop`=1 at the final dwell cycle, the sweep restarts: `phase_inc_carr`<=latched start, `step_idx`<=0, dwell reloaded, state stays DWELL.
  - A restart pulses `done` once per completed pass.
  - Only `abort` or reset leaves a looping sweep.
  - Not defined: no `loop` port; the sweep always returns to IDLE after one pass.

## Structure
- Package `nco_ctrl_pkg` contains:
  - The state enum (`NCO_IDLE`, `NCO_DWELL`).
  - Default `WIDTH`/`CNT_W` constants shared with `nco_sig`.
- Sub-module `nco_dwell_timer` is natural: a loadable down-counter with a `load` input, value `max(d,1)`, and a `last` flag output when the count equals 1.
- `nco_sig` is instantiated by the parent, not inside this block.

## Test plan
- Basic up-sweep: start=0x1000, step=0x100, N=3, D=4 -> `phase_inc_carr` is 0x1000, 0x1100, 0x1200, 0x1300, each for 4 cycles; `done` pulses at cycle 16; `busy` is high for 16 cycles.
- Down-sweep with wrap: start=0x80, step=-0x100 (all-ones pattern ending 0xF00), N=1, D=2 -> tones 0x80, then 0xFFFF_FFFF_FFFF_FF80.
- Degenerate: N=0, D=0 -> a single tone held 1 cycle; `done` is high the cycle after handshake; `cfg_ready` holds to back-to-back descriptors, which are both accepted with one idle cycle between.
- Abort in step 2 of N=5, D=8 -> IDLE the next cycle, no `done`, `phase_inc_carr` holds the step-2 value, `step_idx`=2.
- Async reset asserted mid-dwell -> all outputs reset immediately; the sweep does not resume after `rst_n` rises.
- With `NCO_SWEEP_LOOP_EN`, `loop`=1, N=1, D=3 -> tone pattern A,A,A,B,B,B repeats; `done` pulses every 6 cycles until `abort`.
